// File: rtl/gem_cluster_packer.sv
// gem_cluster_packer: collects GEM cluster words of one bunch crossing into a
// fixed-width frame of MXCLST slots. Unused slots carry FILLER, clusters that
// do not fit are dropped and counted. Completed frames are held until
// downstream takes them; a new frame may start in the same cycle the previous
// one is consumed, so back-to-back single-beat frames stream at one per clock.
module gem_cluster_packer #(
  parameter int                  MXCLST   = 4,
  parameter int                  CLSTBITS = 14,
  parameter logic [CLSTBITS-1:0] FILLER   = 14'h3FFF
) (
  input  logic                         clock,
  input  logic                         global_reset_n,
  input  logic [CLSTBITS-1:0]          clst_in,
  input  logic                         clst_valid,
  input  logic                         clst_last,
  output logic                         clst_ready,
  output logic [MXCLST*CLSTBITS-1:0]   gemdata,
  output logic                         gemdata_valid,
  input  logic                         gemdata_ready,
  output logic [2:0]                   frame_nclst,
  output logic [7:0]                   overflow_cnt,
  output logic [15:0]                  frame_cnt
);

  localparam int          DW    = MXCLST * CLSTBITS;
  localparam logic [2:0]  MAX_N = 3'(MXCLST);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [2:0]      nclst_q, nclst_d;
  logic [7:0]      ovf_q, ovf_d;
  logic [15:0]     fcnt_q, fcnt_d;

  logic            accept_s;
  logic            clst_ok_s;
  logic [DW-1:0]   base_data_s;
  logic [2:0]      base_n_s;

  // Ready is purely a function of the held-frame handshake, never of clst_valid.
  assign clst_ready = (state_q == ST_FILL) | gemdata_ready;
  assign accept_s   = clst_valid & clst_ready;
  // Address field values 11xxxxxxxxx mark an empty/invalid cluster word.
  assign clst_ok_s  = (clst_in[10:9] != 2'b11);

  // Next-state logic: frame hand-off, slot fill, overflow and frame counting.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    nclst_d     = nclst_q;
    ovf_d       = ovf_q;
    fcnt_d      = fcnt_q;
    base_data_s = data_q;
    base_n_s    = nclst_q;

    case (state_q)
      ST_FILL: begin
        base_data_s = data_q;
        base_n_s    = nclst_q;
      end
      ST_HOLD: begin
        if (gemdata_ready) begin
          // Held frame leaves this cycle; whatever follows starts from empty slots.
          fcnt_d      = fcnt_q + 16'd1;
          base_data_s = {MXCLST{FILLER}};
          base_n_s    = 3'd0;
          state_d     = ST_FILL;
          data_d      = {MXCLST{FILLER}};
          nclst_d     = 3'd0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    if (accept_s) begin
      data_d  = base_data_s;
      nclst_d = base_n_s;
      if (clst_ok_s) begin
        if (base_n_s < MAX_N) begin
          data_d[int'(base_n_s)*CLSTBITS +: CLSTBITS] = clst_in;
          nclst_d = base_n_s + 3'd1;
        end else if (ovf_q != 8'hFF) begin
          ovf_d = ovf_q + 8'd1;
        end else begin
          ovf_d = ovf_q;
        end
      end else begin
        nclst_d = base_n_s;
      end
      if (clst_last) begin
        state_d = ST_HOLD;
      end else begin
        state_d = ST_FILL;
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and datapath registers; reset discards any partial or held frame.
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q <= ST_FILL;
      data_q  <= {MXCLST{FILLER}};
      nclst_q <= 3'd0;
      ovf_q   <= 8'd0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      nclst_q <= nclst_d;
      ovf_q   <= ovf_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign gemdata       = data_q;
  assign gemdata_valid = (state_q == ST_HOLD);
  assign frame_nclst   = nclst_q;
  assign overflow_cnt  = ovf_q;
  assign frame_cnt     = fcnt_q;

endmodule

// File: tb/tb_gem_cluster_packer.sv
// Self-checking bench for gem_cluster_packer: directed scenarios followed by
// randomized traffic, all compared against a queue-based frame model.
module tb_gem_cluster_packer;

  logic        clock;
  logic        global_reset_n;
  logic [13:0] clst_in;
  logic        clst_valid;
  logic        clst_last;
  logic        clst_ready;
  logic [55:0] gemdata;
  logic        gemdata_valid;
  logic        gemdata_ready;
  logic [2:0]  frame_nclst;
  logic [7:0]  overflow_cnt;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_cur[$];
  bit          m_hold;
  logic [55:0] m_frame;
  int          m_n;
  int          m_ovf;
  int          m_fcnt;

  gem_cluster_packer dut (
    .clock         (clock),
    .global_reset_n(global_reset_n),
    .clst_in       (clst_in),
    .clst_valid    (clst_valid),
    .clst_last     (clst_last),
    .clst_ready    (clst_ready),
    .gemdata       (gemdata),
    .gemdata_valid (gemdata_valid),
    .gemdata_ready (gemdata_ready),
    .frame_nclst   (frame_nclst),
    .overflow_cnt  (overflow_cnt),
    .frame_cnt     (frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] build_frame(input int q[$]);
    logic [55:0] f;
    f = '1;
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) f[i*14 +: 14] = 14'(q[i]);
      else              f[i*14 +: 14] = 14'h3FFF;
    end
    return f;
  endfunction

  task automatic model_reset();
    m_cur.delete();
    m_hold  = 1'b0;
    m_frame = {4{14'h3FFF}};
    m_n     = 0;
    m_ovf   = 0;
    m_fcnt  = 0;
  endtask

  task automatic model_step(input bit acc, input logic [13:0] d, input bit l, input bit r);
    if (m_hold && r) begin
      m_fcnt = (m_fcnt + 1) % 65536;
      m_hold = 1'b0;
    end
    if (acc) begin
      if (d[10:9] != 2'b11) begin
        if (m_cur.size() < 4) m_cur.push_back(int'(d));
        else if (m_ovf < 255) m_ovf++;
      end
      if (l) begin
        m_frame = build_frame(m_cur);
        m_n     = m_cur.size();
        m_hold  = 1'b1;
        m_cur.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("gemdata_valid", 64'(gemdata_valid), 64'(m_hold));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
    chk("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
    if (m_hold) begin
      chk("gemdata", 64'(gemdata), 64'(m_frame));
      chk("frame_nclst", 64'(frame_nclst), 64'(m_n));
    end
  endtask

  // One clock: drive at negedge, check ready, step model at posedge, check outputs.
  task automatic cycle(input bit v, input logic [13:0] d, input bit l, input bit r);
    bit acc;
    clst_valid    = v;
    clst_in       = d;
    clst_last     = l;
    gemdata_ready = r;
    #1;
    chk("clst_ready", 64'(clst_ready), 64'(!m_hold || r));
    acc = v && (!m_hold || r);
    @(posedge clock);
    model_step(acc, d, l, r);
    #1;
    check_outputs();
    @(negedge clock);
  endtask

  task automatic check_reset_vals();
    chk("rst_gemdata_valid", 64'(gemdata_valid), 64'd0);
    chk("rst_gemdata", 64'(gemdata), 64'({4{14'h3FFF}}));
    chk("rst_frame_nclst", 64'(frame_nclst), 64'd0);
    chk("rst_overflow_cnt", 64'(overflow_cnt), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
  endtask

  // Assert reset mid-cycle, check immediately, release on a falling edge.
  task automatic do_reset();
    #2;
    global_reset_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) @(negedge clock);
    global_reset_n = 1'b1;
  endtask

  initial begin
    logic [55:0] f_before;
    global_reset_n = 1'b1;
    clst_in = 14'h0; clst_valid = 1'b0; clst_last = 1'b0; gemdata_ready = 1'b0;
    @(negedge clock);
    do_reset();
    #1;
    chk("ready_after_reset", 64'(clst_ready), 64'd1);

    // Two-cluster frame consumed immediately
    cycle(1'b1, 14'h0005, 1'b0, 1'b1);
    cycle(1'b1, 14'h1843, 1'b1, 1'b1);
    chk("two_clst_frame", 64'(gemdata), 64'({14'h3FFF, 14'h3FFF, 14'h1843, 14'h0005}));
    chk("two_clst_nclst", 64'(frame_nclst), 64'd2);
    cycle(1'b0, 14'h0000, 1'b0, 1'b1);
    chk("two_clst_fcnt", 64'(frame_cnt), 64'd1);
    chk("two_clst_valid_drop", 64'(gemdata_valid), 64'd0);

    // Empty bunch crossing marker
    cycle(1'b1, 14'h3FFF, 1'b1, 1'b0);
    chk("empty_frame", 64'(gemdata), 64'({4{14'h3FFF}}));
    chk("empty_nclst", 64'(frame_nclst), 64'd0);

    // Overflow: six valid clusters, last on the sixth (consumes empty frame first)
    for (int i = 1; i <= 6; i++) cycle(1'b1, 14'(i), i == 6, 1'b1);
    chk("ovf_frame", 64'(gemdata), 64'({14'h0004, 14'h0003, 14'h0002, 14'h0001}));
    chk("ovf_nclst", 64'(frame_nclst), 64'd4);
    chk("ovf_cnt", 64'(overflow_cnt), 64'd2);

    // Backpressure for five cycles with input pending
    f_before = gemdata;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 14'h0123, 1'b1, 1'b0);
      chk("bp_stable", 64'(gemdata), 64'(f_before));
    end
    cycle(1'b1, 14'h0123, 1'b1, 1'b1);
    chk("bp_new_frame", 64'(gemdata[13:0]), 64'(14'h0123));

    // Back-to-back single-beat frames
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 14'(16'h0200 + 16'(i)), 1'b1, 1'b1);
      chk("b2b_valid", 64'(gemdata_valid), 64'd1);
    end
    cycle(1'b0, 14'h0000, 1'b0, 1'b1);

    // Reset during an open frame
    cycle(1'b1, 14'h0011, 1'b0, 1'b1);
    cycle(1'b1, 14'h0022, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 14'h0033, 1'b1, 1'b0);
    chk("post_rst_slot0", 64'(gemdata), 64'({14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h0033}));
    chk("post_rst_nclst", 64'(frame_nclst), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, 14'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 7);
    end

    // Overflow saturation: long frame with many valid clusters
    for (int i = 0; i < 300; i++) cycle(1'b1, 14'h0042, 1'b0, 1'b1);
    cycle(1'b1, 14'h0042, 1'b1, 1'b1);
    chk("ovf_saturated", 64'(overflow_cnt), 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gem_cluster_packer.md
GEM_CLUSTER_PACKER -- requirements
Module: gem_cluster_packer

Interface
REQ-001 Parameter MXCLST, default 4: cluster slots per frame.
REQ-002 Parameter CLSTBITS, default 14: bits per cluster word.
REQ-003 Parameter FILLER, default 14'h3FFF: word placed in unused slots (adr[10:9]=2'b11, invalid).
REQ-004 clock  input  1  40MHz TMB system clock; single clock domain.
REQ-005 global_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 clst_in  input  14  cluster word: cnt=[13:11], adr=[10:0].
REQ-007 clst_valid  input  1  clst_in/clst_last valid.
REQ-008 clst_last  input  1  beat closes current bunch-crossing frame.
REQ-009 clst_ready  output  1  packer accepts beat this cycle.
REQ-010 gemdata  output  56  packed frame; slot i at [14*i+13:14*i].
REQ-011 gemdata_valid  output  1  gemdata holds a complete frame.
REQ-012 gemdata_ready  input  1  downstream consumes frame.
REQ-013 frame_nclst  output  3  count of valid clusters in held frame, 0-4.
REQ-014 overflow_cnt  output  8  saturating count of valid clusters dropped (5th+ in one frame).
REQ-015 frame_cnt  output  16  wrapping count of frames consumed downstream.

Function
REQ-016 Beat accepted iff clst_valid & clst_ready on a rising clock edge.
REQ-017 Cluster "valid" iff clst_in[10:9] != 2'b11 (implies adr[10:6] <= 23).
REQ-018 Two states: FILL (assembling, gemdata_valid=0) and HOLD (frame complete, gemdata_valid=1).
REQ-019 clst_ready = (state==FILL) | gemdata_ready; combinational, no dependency on clst_valid.
REQ-020 FILL, accepted valid cluster with slots used < 4: store in next slot in arrival order, increment slot count.
REQ-021 FILL, accepted valid cluster with 4 slots used: discard; overflow_cnt +1, saturating at 255.
REQ-022 Accepted invalid cluster: never stored, never counted; its clst_last still honoured (empty-bx marker).
REQ-023 Accepted beat with clst_last=1: frame closes including that beat; next cycle state=HOLD, gemdata_valid=1.
REQ-024 gemdata and frame_nclst registered; stable throughout HOLD; unused slots = FILLER.
REQ-025 Frame with zero valid clusters: all four slots FILLER, frame_nclst=0, emitted normally.
REQ-026 HOLD & gemdata_ready & no accepted beat: next state FILL, slots cleared, frame_cnt +1 (wraps 65535->0).
REQ-027 HOLD & gemdata_ready & accepted beat: frame_cnt +1; beat starts new frame in slot 0 per REQ-020/022; if clst_last=1, stay HOLD with the new frame (back-to-back, one frame per clock).
REQ-028 HOLD & !gemdata_ready: clst_ready=0; no input consumed; gemdata unchanged.
REQ-029 Latency: last beat accepted at edge N -> gemdata_valid high after edge N.
REQ-030 No cluster reordering, merging, or cnt/adr modification.

Reset
REQ-031 global_reset_n low asynchronously forces state=FILL, slots cleared.
REQ-032 Reset values: gemdata_valid=0, gemdata={4{FILLER}}, frame_nclst=0, overflow_cnt=0, frame_cnt=0.
REQ-033 Reset mid-frame or during HOLD discards the partial/held frame without incrementing any counter.
REQ-034 clst_ready=1 from the first clock edge after reset release (FILL state).

Verification
REQ-035 Beats 14'h0005, 14'h1843(last), gemdata_ready=1 -> one cycle gemdata_valid; gemdata={3FFF,3FFF,1843,0005}, frame_nclst=2, frame_cnt=1.
REQ-036 Single beat 14'h3FFF last -> frame all FILLER, frame_nclst=0, overflow_cnt=0.
REQ-037 Six valid beats 14'h0001..0006, last on 6th -> slots 0001..0004, frame_nclst=4, overflow_cnt=2.
REQ-038 gemdata_ready=0 for 5 cycles while clst_valid=1 -> clst_ready=0, gemdata stable; ready high -> frame_cnt+1, next beat accepted same cycle.
REQ-039 Continuous single-beat last frames, gemdata_ready=1 -> gemdata_valid stays high, new frame every clock, frame_cnt increments every clock.
REQ-040 global_reset_n pulsed low after 2 beats of open frame -> all outputs at reset values immediately; next frame starts at slot 0.
